// File: rtl/sdl_video_pkg.sv
// Shared types and helpers for the SDL/VGA output stage.
// Used by sdl_video_out; see that file for the SDL_TEST_PATTERN_EN build option.
package sdl_video_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } sw_state_e;

  localparam int FRAME_CNT_W = 16;

  // Replicates the low 'width' bits of value MSB-first across 8 bits.
  function automatic logic [7:0] expand_color(input logic [7:0] value, input int width);
    logic [7:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      res[3'(7 - i)] = value[3'(width - 1 - (i % width))];
    end
    return res;
  endfunction

endpackage

// File: rtl/sdl_delay_line.sv
// WIDTH x DEPTH shift register with asynchronous clear; DEPTH=0 is a plain wire.
module sdl_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    assign q_o = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/sdl_video_out.sv
// SDL/VGA output stage: source select with frame-boundary switching, alignment, expansion, stats.
// Build option SDL_TEST_PATTERN_EN adds test_pat, which replaces colour with 8 vertical bars.
module sdl_video_out
  import sdl_video_pkg::*;
#(
  parameter  int NUM_SRC = 2,
  parameter  int COLOR_W = 4,
  parameter  int COORD_W = 12,
  parameter  int SRC_LAT = 1,
  localparam int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                         pixel_clk,
  input  logic                         sim_rst,
  input  logic [COORD_W-1:0]           h_coord,
  input  logic [COORD_W-1:0]           v_coord,
  input  logic                         disp_enbl,
  input  logic [NUM_SRC*3*COLOR_W-1:0] src_rgb,
  input  logic [SEL_W-1:0]             src_sel,
`ifdef SDL_TEST_PATTERN_EN
  input  logic                         test_pat,
`endif
  output logic [COORD_W-1:0]           sdl_sx,
  output logic [COORD_W-1:0]           sdl_sy,
  output logic                         sdl_de,
  output logic [7:0]                   sdl_r,
  output logic [7:0]                   sdl_g,
  output logic [7:0]                   sdl_b,
  output logic                         frame_start,
  output logic [FRAME_CNT_W-1:0]       frame_cnt,
  output logic [SEL_W-1:0]             active_src
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam int DLY_W = 2 * COORD_W + 1;

  logic [DLY_W-1:0]   dly;
  logic [COORD_W-1:0] dly_h, dly_v;
  logic               dly_de;
  logic               boundary;

  sdl_delay_line #(.WIDTH(DLY_W), .DEPTH(SRC_LAT)) u_align (
    .clk_i (pixel_clk),
    .rst_i (sim_rst),
    .d_i   ({disp_enbl, v_coord, h_coord}),
    .q_o   (dly)
  );

  assign {dly_de, dly_v, dly_h} = dly;
  assign boundary = dly_de && (dly_h == '0) && (dly_v == '0);

  logic [PIX_W-1:0] src_pix [NUM_SRC];
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_pix[i] = src_rgb[i*PIX_W +: PIX_W];
  end

  sw_state_e        state_q;
  logic [SEL_W-1:0] active_q, pend_q;
  logic             sel_valid;

  assign sel_valid = int'(src_sel) < NUM_SRC;

  // Boundary wins over any src_sel activity in the same cycle; that request is seen next cycle.
  always_ff @(posedge pixel_clk or posedge sim_rst) begin
    if (sim_rst) begin
      state_q  <= IDLE;
      active_q <= '0;
      pend_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_valid && (src_sel != active_q)) begin
            pend_q  <= src_sel;
            state_q <= PENDING;
          end
        end
        PENDING: begin
          if (boundary) begin
            active_q <= pend_q;
            state_q  <= IDLE;
          end else if (src_sel == active_q) begin
            state_q <= IDLE;
          end else if (sel_valid) begin
            pend_q <= src_sel;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The boundary pixel already takes its colour from the incoming source.
  logic [SEL_W-1:0] colour_sel;
  logic [PIX_W-1:0] pix;
  logic [7:0]       r_d, g_d, b_d;

  assign colour_sel = (state_q == PENDING && boundary) ? pend_q : active_q;
  assign pix        = src_pix[colour_sel];

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (dly_de) begin
      r_d = expand_color(8'(pix[PIX_W-1 -: COLOR_W]), COLOR_W);
      g_d = expand_color(8'(pix[2*COLOR_W-1 -: COLOR_W]), COLOR_W);
      b_d = expand_color(8'(pix[COLOR_W-1:0]), COLOR_W);
`ifdef SDL_TEST_PATTERN_EN
      if (test_pat) begin
        r_d = {8{dly_h[9]}};
        g_d = {8{dly_h[8]}};
        b_d = {8{dly_h[7]}};
      end
`endif
    end
  end

  logic [COORD_W-1:0]     sx_q, sy_q;
  logic                   de_q, fs_q;
  logic [7:0]             r_q, g_q, b_q;
  logic [FRAME_CNT_W-1:0] cnt_q;

  always_ff @(posedge pixel_clk or posedge sim_rst) begin
    if (sim_rst) begin
      sx_q  <= '0;
      sy_q  <= '0;
      de_q  <= 1'b0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
      fs_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      sx_q <= dly_h;
      sy_q <= dly_v;
      de_q <= dly_de;
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      fs_q <= boundary;
      if (boundary) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign sdl_sx      = sx_q;
  assign sdl_sy      = sy_q;
  assign sdl_de      = de_q;
  assign sdl_r       = r_q;
  assign sdl_g       = g_q;
  assign sdl_b       = b_q;
  assign frame_start = fs_q;
  assign frame_cnt   = cnt_q;
  assign active_src  = active_q;

endmodule

// File: tb/tb_sdl_video_out.sv
// Directed + randomized bench for sdl_video_out (NUM_SRC=3, COLOR_W=3, SRC_LAT=2).
module tb_sdl_video_out;

  localparam int NUM_SRC = 3;
  localparam int COLOR_W = 3;
  localparam int COORD_W = 12;
  localparam int SRC_LAT = 2;
  localparam int SEL_W   = 2;
  localparam int PIX_W   = 3 * COLOR_W;
  localparam int RGB_W   = NUM_SRC * PIX_W;
  localparam int W = 20, H = 10, AW = 16, AH = 8;

  logic               pixel_clk = 1'b0;
  logic               sim_rst;
  logic [COORD_W-1:0] h_coord, v_coord;
  logic               disp_enbl;
  logic [RGB_W-1:0]   src_rgb;
  logic [SEL_W-1:0]   src_sel;
`ifdef SDL_TEST_PATTERN_EN
  logic               test_pat = 1'b0;
`endif
  logic [COORD_W-1:0] sdl_sx, sdl_sy;
  logic               sdl_de;
  logic [7:0]         sdl_r, sdl_g, sdl_b;
  logic               frame_start;
  logic [15:0]        frame_cnt;
  logic [SEL_W-1:0]   active_src;

  sdl_video_out #(
    .NUM_SRC(NUM_SRC), .COLOR_W(COLOR_W), .COORD_W(COORD_W), .SRC_LAT(SRC_LAT)
  ) dut (
    .pixel_clk   (pixel_clk),
    .sim_rst     (sim_rst),
    .h_coord     (h_coord),
    .v_coord     (v_coord),
    .disp_enbl   (disp_enbl),
    .src_rgb     (src_rgb),
    .src_sel     (src_sel),
`ifdef SDL_TEST_PATTERN_EN
    .test_pat    (test_pat),
`endif
    .sdl_sx      (sdl_sx),
    .sdl_sy      (sdl_sy),
    .sdl_de      (sdl_de),
    .sdl_r       (sdl_r),
    .sdl_g       (sdl_g),
    .sdl_b       (sdl_b),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt),
    .active_src  (active_src)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic [COORD_W-1:0] h;
    logic [COORD_W-1:0] v;
    logic               de;
  } pix_t;

  pix_t        pipe[$];
  int          active_m, want_m;
  logic [15:0] cnt_m;
  int          checks = 0, failures = 0;
  int          hc = 0, vc = 0;
  logic [1:0]  sel_cur = 2'd0;

  function automatic logic [7:0] ref_expand(input logic [COLOR_W-1:0] c);
    logic [31:0] acc;
    int bits;
    acc = 0;
    bits = 0;
    while (bits < 8) begin
      acc = (acc << COLOR_W) | 32'(c);
      bits += COLOR_W;
    end
    return 8'(acc >> (bits - 8));
  endfunction

  task automatic model_reset();
    pipe.delete();
    repeat (SRC_LAT) pipe.push_back('{h: '0, v: '0, de: 1'b0});
    active_m = 0;
    want_m   = 0;
    cnt_m    = 16'h0;
  endtask

  // Drives one pixel at the falling edge, predicts the outputs of the next rising edge, checks them.
  task automatic step(input logic [COORD_W-1:0] h, input logic [COORD_W-1:0] v, input logic de,
                      input logic [RGB_W-1:0] rgb, input logic [1:0] sel);
    pix_t d;
    logic bnd;
    logic [PIX_W-1:0] px;
    logic [7:0] er, eg, eb;
    h_coord = h; v_coord = v; disp_enbl = de; src_rgb = rgb; src_sel = sel;
    @(posedge pixel_clk);
    pipe.push_back('{h: h, v: v, de: de});
    d = pipe.pop_front();
    bnd = d.de && d.h == 0 && d.v == 0;
    if (bnd) begin
      active_m = want_m;
      cnt_m    = cnt_m + 16'd1;
    end
    if (int'(sel) < NUM_SRC) want_m = int'(sel);
    px = PIX_W'(rgb >> (active_m * PIX_W));
    er = d.de ? ref_expand(px[8:6]) : 8'h00;
    eg = d.de ? ref_expand(px[5:3]) : 8'h00;
    eb = d.de ? ref_expand(px[2:0]) : 8'h00;
    #1;
    checks++;
    assert ({sdl_sx, sdl_sy, sdl_de} === {d.h, d.v, d.de}) else begin
      failures++;
      $error("FAIL coords observed=%h/%h/%b expected=%h/%h/%b", sdl_sx, sdl_sy, sdl_de, d.h, d.v, d.de);
    end
    checks++;
    assert ({sdl_r, sdl_g, sdl_b} === {er, eg, eb}) else begin
      failures++;
      $error("FAIL colour observed=%h%h%h expected=%h%h%h", sdl_r, sdl_g, sdl_b, er, eg, eb);
    end
    checks++;
    assert ({frame_start, frame_cnt, active_src} === {bnd, cnt_m, SEL_W'(active_m)}) else begin
      failures++;
      $error("FAIL frame observed fs=%b cnt=%h src=%0d expected fs=%b cnt=%h src=%0d",
             frame_start, frame_cnt, active_src, bnd, cnt_m, active_m);
    end
    @(negedge pixel_clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step(COORD_W'(hc), COORD_W'(vc), (hc < AW) && (vc < AH), RGB_W'($urandom), sel_cur);
      hc++;
      if (hc == W) begin
        hc = 0;
        vc = (vc + 1) % H;
      end
    end
  endtask

  task automatic run_until_fs(input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      run(1);
      seen = frame_start;
    end
    checks++;
    assert (seen) else begin
      failures++;
      $error("FAIL fs_timeout observed=no frame_start expected=frame_start within %0d cycles", maxc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    assert ({sdl_sx, sdl_sy, sdl_de, sdl_r, sdl_g, sdl_b, frame_start, frame_cnt, active_src} === '0) else begin
      failures++;
      $error("FAIL %s observed sx=%h sy=%h de=%b rgb=%h%h%h fs=%b cnt=%h src=%0d expected all zero",
             tag, sdl_sx, sdl_sy, sdl_de, sdl_r, sdl_g, sdl_b, frame_start, frame_cnt, active_src);
    end
  endtask

  initial begin
    logic [RGB_W-1:0] rgb;
    logic [15:0] prev_cnt;
    bit wrapped;

    sim_rst = 1'b1;
    h_coord = '0; v_coord = '0; disp_enbl = 1'b0; src_rgb = '0; src_sel = '0;
    model_reset();
    repeat (2) @(negedge pixel_clk);
    check_all_zero("reset_state");
    sim_rst = 1'b0;

    // Alignment and expansion: pixel (5,3) and its colour two cycles later.
    step(12'd5, 12'd3, 1'b1, RGB_W'($urandom), 2'd0);
    step(12'd6, 12'd3, 1'b1, RGB_W'($urandom), 2'd0);
    rgb = RGB_W'($urandom);
    rgb[8:0] = 9'b101_011_000;
    step(12'd7, 12'd3, 1'b1, rgb, 2'd0);
    checks++;
    assert ({sdl_sx, sdl_r, sdl_g, sdl_b} === {12'd5, 8'hB6, 8'h6D, 8'h00}) else begin
      failures++;
      $error("FAIL align_expand observed sx=%0d rgb=%h%h%h expected sx=5 rgb=b66d00", sdl_sx, sdl_r, sdl_g, sdl_b);
    end

    // Blanking with all sources at full scale.
    step(12'd1, 12'd1, 1'b0, '1, 2'd0);
    step(12'd2, 12'd1, 1'b0, '1, 2'd0);
    step(12'd3, 12'd1, 1'b0, '1, 2'd0);
    checks++;
    assert ({sdl_r, sdl_g, sdl_b} === 24'h0) else begin
      failures++;
      $error("FAIL blanking observed=%h%h%h expected=000000", sdl_r, sdl_g, sdl_b);
    end

    // Mid-frame switch request 0 -> 1.
    hc = 0; vc = 0; sel_cur = 2'd0;
    run(W * 3);
    sel_cur = 2'd1;
    run(20);
    checks++;
    assert (active_src === 2'd0) else begin
      failures++;
      $error("FAIL switch_hold observed=%0d expected=0", active_src);
    end
    run_until_fs(W * H + 10);
    checks++;
    assert (active_src === 2'd1) else begin
      failures++;
      $error("FAIL switch_take observed=%0d expected=1", active_src);
    end

    // Out-of-range request is ignored.
    sel_cur = 2'd3;
    run(W * H + 10);
    checks++;
    assert (active_src === 2'd1) else begin
      failures++;
      $error("FAIL invalid_sel observed=%0d expected=1", active_src);
    end

    // Request arriving on the boundary cycle is taken one frame later.
    while (!(hc == 2 && vc == 0)) run(1);
    sel_cur = 2'd2;
    run(1);
    checks++;
    assert ({frame_start, active_src} === {1'b1, 2'd1}) else begin
      failures++;
      $error("FAIL boundary_req observed fs=%b src=%0d expected fs=1 src=1", frame_start, active_src);
    end
    run_until_fs(W * H + 10);
    checks++;
    assert (active_src === 2'd2) else begin
      failures++;
      $error("FAIL boundary_req_next observed=%0d expected=2", active_src);
    end

    // Randomized source requests over several frames.
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 39) == 0) sel_cur = 2'($urandom_range(0, 3));
      run(1);
    end

    // Asynchronous reset in the middle of a frame.
    step(12'd400, 12'd300, 1'b1, RGB_W'($urandom), sel_cur);
    #2 sim_rst = 1'b1;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge pixel_clk);
    sim_rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) sel_cur = 2'($urandom_range(0, 3));
      run(1);
    end

    // Frame counter wrap with single-pixel frames.
    sel_cur = 2'd0;
    run(W * H * 2 + 5);
    wrapped  = 1'b0;
    prev_cnt = frame_cnt;
    for (int i = 0; i < 65540; i++) begin
      step(12'd0, 12'd0, 1'b1, RGB_W'($urandom), sel_cur);
      if (prev_cnt == 16'hFFFF && frame_cnt == 16'h0000) wrapped = 1'b1;
      prev_cnt = frame_cnt;
    end
    checks++;
    assert (wrapped) else begin
      failures++;
      $error("FAIL cnt_wrap observed=no FFFF->0000 transition expected=wrap, last cnt=%h", frame_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
